// File: rtl/wand_bus_pkg.sv
// Shared types for the wired-AND bus arbiter: bus word, idle pattern, FSM states.
package wand_bus_pkg;
  typedef logic [2:0][4:2] bus_word_t;
  localparam bus_word_t BUS_IDLE = '1;
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: rotate requests by ptr, take lowest set bit, rotate back.
// Purely combinational; o_any qualifies o_idx/o_onehot.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic            o_any,
  output logic [PW-1:0]   o_idx,
  output logic [NREQ-1:0] o_onehot
);
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [PW-1:0]     w_k;
  logic [PW:0]       w_sum;

  always_comb begin
    w_dbl = {i_req, i_req};
    w_rot = NREQ'(w_dbl >> i_ptr);
    w_k   = '0;
    // Descending scan so the lowest rotated position wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_k = PW'(k);
    end
    w_sum = {1'b0, w_k} + {1'b0, i_ptr};
    if (w_sum >= (PW + 1)'(NREQ)) w_sum = w_sum - (PW + 1)'(NREQ);
    o_any    = |i_req;
    o_idx    = w_sum[PW-1:0];
    o_onehot = NREQ'(1) << o_idx;
  end
endmodule

// File: rtl/wand_bus_arbiter.sv
// Round-robin owner of a shared wired-AND bus: one grant at a time, bounded
// tenure, one turnaround cycle, all-ones on the bus whenever nobody owns it.
module wand_bus_arbiter
  import wand_bus_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic      [NREQ-1:0]  req,
  input  logic      [NREQ-1:0]  last,
  input  bus_word_t [NREQ-1:0]  data,
  output logic      [NREQ-1:0]  gnt,
  output bus_word_t             bus_out,
  output logic                  bus_vld,
  output logic                  busy
);
  localparam int PW = $clog2(NREQ);

  arb_state_t      r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic [3:0]      r_hold;
  logic [NREQ-1:0] r_gnt;
  bus_word_t       r_bus;
  logic            r_vld;

  logic            w_any;
  logic [PW-1:0]   w_idx;
  logic [NREQ-1:0] w_onehot;
  logic [PW-1:0]   w_next_ptr;
  logic            w_end_beat;
  bus_word_t       w_and;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_any    (w_any),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  // Ungranted drivers contribute all-ones, so their data (even X) is masked.
  always_comb begin
    w_and = BUS_IDLE;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gnt[i]) w_and = w_and & data[i];
    end
  end

  assign w_next_ptr = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + PW'(1);
  assign w_end_beat = last[r_owner] || (r_hold == 4'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_bus   <= BUS_IDLE;
      r_vld   <= 1'b0;
      r_ptr   <= '0;
      r_owner <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_bus <= BUS_IDLE;
          r_vld <= 1'b0;
          if (w_any) begin
            r_gnt   <= w_onehot;
            r_owner <= w_idx;
            r_hold  <= '0;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (req[r_owner]) begin
            r_bus  <= w_and;
            r_vld  <= 1'b1;
            r_hold <= r_hold + 4'd1;
            if (w_end_beat) begin
              r_gnt   <= '0;
              r_ptr   <= w_next_ptr;
              r_state <= RELEASE;
            end
          end else begin
            // Owner walked away without a last beat: abandon the tenure.
            r_bus   <= BUS_IDLE;
            r_vld   <= 1'b0;
            r_gnt   <= '0;
            r_ptr   <= w_next_ptr;
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          r_bus   <= BUS_IDLE;
          r_vld   <= 1'b0;
          r_gnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign bus_out = r_bus;
  assign bus_vld = r_vld;
  assign busy    = (r_state != IDLE);
endmodule

// File: tb/tb_wand_bus_arbiter.sv
// Directed scenarios then random traffic, every cycle compared to a tenure-level model.
module tb_wand_bus_arbiter;
  import wand_bus_pkg::*;

  localparam int N  = 4;
  localparam int MH = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req, last, gnt;
  bus_word_t [N-1:0]   data;
  bus_word_t           bus_out;
  logic                bus_vld, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: who owns the bus, how many beats so far, turnaround pending.
  int           m_own = -1;
  bit           m_rel = 0;
  int           m_ptr = 0;
  int           m_cnt = 0;
  logic [N-1:0] e_gnt = '0;
  bus_word_t    e_bus = '1;
  logic         e_vld = 1'b0;

  int           grant_q[$];
  int           run_q[$];
  int           run_len;
  logic [N-1:0] prev_gnt;

  always #5 clk = ~clk;

  wand_bus_arbiter #(.NREQ(N), .MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .last    (last),
    .data    (data),
    .gnt     (gnt),
    .bus_out (bus_out),
    .bus_vld (bus_vld),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    e_bus = '1;
    e_vld = 1'b0;
    if (rst) begin
      m_own = -1; m_rel = 0; m_ptr = 0; m_cnt = 0; e_gnt = '0;
    end else if (m_rel) begin
      m_rel = 0;
    end else if (m_own < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_own < 0 && req[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
      end
      if (m_own >= 0) begin
        m_cnt = 0;
        e_gnt = N'(1) << m_own;
      end
    end else begin
      bit done;
      done = 1;
      if (req[m_own]) begin
        e_bus = data[m_own];
        e_vld = 1'b1;
        m_cnt++;
        done = last[m_own] || (m_cnt == MH);
      end
      if (done) begin
        m_ptr = (m_own + 1) % N;
        m_own = -1;
        m_rel = 1;
        e_gnt = '0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("bus_out", 32'(bus_out), 32'(e_bus));
    chk("bus_vld", 32'(bus_vld), 32'(e_vld));
    chk("busy", 32'(busy), 32'(m_own >= 0 || m_rel));
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; last = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    rst = 1'b1; req = '1; last = '0;
    for (int i = 0; i < N; i++) data[i] = bus_word_t'($urandom);

    // Reset held with all requests asserted.
    repeat (3) begin
      step();
      chk("rst_bus", 32'(bus_out), 32'h1FF);
    end
    rst = 1'b0;
    step();
    chk("first_gnt", 32'(gnt), 32'h1);
    req = '0;
    repeat (4) step();

    // Single requester, last on second beat, then the pointer sits at 3.
    do_reset();
    req = 4'b0100; data[2] = 9'h0A5;
    step();
    chk("s2_gnt", 32'(gnt), 32'h4);
    step();
    chk("s2_beat1", 32'(bus_out), 32'h0A5);
    last = 4'b0100;
    step();
    chk("s2_beat2", 32'(bus_out), 32'h0A5);
    last = '0; req = '0;
    step();
    chk("s2_release", 32'(bus_out), 32'h1FF);
    step();
    chk("s2_idle_busy", 32'(busy), 32'h0);
    req = '1;
    step();
    chk("s2_ptr3", 32'(gnt), 32'h8);
    req = '0;
    repeat (3) step();

    // All requesting, no last: fixed-length tenures in rotation.
    do_reset();
    req = '1; last = '0;
    prev_gnt = '0; run_len = 0;
    repeat (34) begin
      for (int i = 0; i < N; i++) data[i] = bus_word_t'($urandom);
      step();
      if (gnt != 0 && prev_gnt == 0) begin
        for (int i = 0; i < N; i++) if (gnt[i]) grant_q.push_back(i);
      end
      prev_gnt = gnt;
      if (bus_vld) run_len++;
      else if (run_len != 0) begin
        run_q.push_back(run_len);
        run_len = 0;
      end
    end
    chk("s3_ngrants", 32'(grant_q.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < grant_q.size(); i++) chk("s3_order", 32'(grant_q[i]), 32'(exp_order[i]));
    chk("s3_nruns", 32'(run_q.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < run_q.size(); i++) chk("s3_beats", 32'(run_q[i]), MH);

    // Owner drops its request mid-tenure; next requester gets the bus.
    do_reset();
    req = 4'b0001;
    step(); step(); req = '0; repeat (3) step();
    req = 4'b0010;
    step(); step();
    req = 4'b0100;
    step();
    chk("s4_drop_vld", 32'(bus_vld), 32'h0);
    chk("s4_drop_gnt", 32'(gnt), 32'h0);
    step(); step();
    chk("s4_next", 32'(gnt), 32'h4);
    req = '0;
    repeat (3) step();

    // Unknown data on a non-owner must not leak onto the bus.
    do_reset();
    req = 4'b1001; data[0] = 9'h000; data[3] = 'x;
    step(); step();
    chk("s5_bus", 32'(bus_out), 32'h000);
    repeat (6) step();
    data[3] = 9'h1FF;

    // Reset during the second beat.
    do_reset();
    req = 4'b0010;
    step(); step();
    rst = 1'b1;
    step();
    chk("s6_gnt", 32'(gnt), 32'h0);
    chk("s6_bus", 32'(bus_out), 32'h1FF);
    rst = 1'b0; req = '1;
    step();
    chk("s6_ptr0", 32'(gnt), 32'h1);

    // Random traffic.
    repeat (600) begin
      rst  = ($urandom_range(0, 59) == 0);
      req  = N'($urandom);
      last = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      for (int i = 0; i < N; i++) data[i] = bus_word_t'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
